// File: rtl/uart_loader_pkg.sv
// ktc32_loader_pkg: loader and RX state encodings plus shared constants.
// Rev 1.0. Optional macro LOADER_CHECKSUM_EN adds the S_CSUM state.
`default_nettype none

package ktc32_loader_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM   = 3'd3,
`endif
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop input synchronizer, start-bit recheck and framing detect.
// Rev 1.0.
`default_nettype none

module uart_rx
  import ktc32_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic [1:0]    sync_ff;
  logic          rx_s;
  logic          rx_prev;
  logic          fall;
  rx_state_t     state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_full;
  logic          cnt_half;

  assign rx_s     = sync_ff[1];
  assign fall     = rx_prev & ~rx_s;
  assign cnt_full = (cnt == CW'(CLKS_PER_BIT - 1));
  assign cnt_half = (cnt == CW'(CLKS_PER_BIT / 2 - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      // A line that is high again at mid start bit was only a glitch.
      RX_START: if (cnt_half) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_full && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (cnt_full) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff     <= 2'b11;
      rx_prev     <= 1'b1;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync_ff     <= {sync_ff[0], rx};
      rx_prev     <= rx_s;
      byte_valid  <= (state == RX_STOP) && cnt_full && rx_s;
      framing_err <= (state == RX_STOP) && cnt_full && !rx_s;
      if (state == RX_IDLE || state_next != state || (state == RX_DATA && cnt_full)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == RX_START) begin
        bit_idx <= '0;
      end else if (state == RX_DATA && cnt_full) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign byte_data = shreg;

endmodule

`default_nettype wire

// File: rtl/uart_loader.sv
// uart_loader: receives a length-prefixed word image over UART and writes it to instruction RAM.
// Rev 1.0. Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
`default_nettype none

module uart_loader
  import ktc32_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [16:0] MAX_WORDS    = 17'd1 << ADDR_WIDTH;
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = S_CSUM;
`else
  localparam loader_state_t AFTER_DATA = S_DONE;
`endif

  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              framing_err;
  loader_state_t     state, state_next;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [ADDR_WIDTH:0] word_idx;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [16:0]       new_len;
  logic              word_complete;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .framing_err(framing_err)
  );

  assign new_len       = {1'b0, byte_data, len_lo};
  assign word_complete = (byte_cnt == 2'(WORD_BYTES - 1));
  assign last_word     = (17'(word_idx) + 17'd1 == {1'b0, len});

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LEN_LO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (framing_err && state != S_DONE && state != S_ERR) begin
      state_next = S_ERR;
    end else if (byte_valid) begin
      case (state)
        S_LEN_LO: state_next = S_LEN_HI;
        S_LEN_HI: begin
          if (new_len > MAX_WORDS)  state_next = S_ERR;
          else if (new_len == '0)   state_next = AFTER_DATA;
          else                      state_next = S_DATA;
        end
        S_DATA:   if (word_complete && last_word) state_next = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
        S_CSUM:   state_next = (byte_data == csum) ? S_DONE : S_ERR;
`endif
        default:  state_next = state;
      endcase
    end
  end

  always_comb begin
    cpu_hold = (state != S_DONE);
    done     = (state == S_DONE);
    error    = (state == S_ERR);
  end

  // Bytes arrive little-endian: shift the first three down, merge the fourth on top.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      byte_cnt  <= '0;
      word_buf  <= '0;
      word_idx  <= '0;
      len_lo    <= '0;
      len       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (byte_valid) begin
        case (state)
          S_LEN_LO: len_lo <= byte_data;
          S_LEN_HI: len    <= new_len[15:0];
          S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_data;
`endif
            byte_cnt <= byte_cnt + 2'd1;
            word_buf <= {byte_data, word_buf[23:8]};
            if (word_complete) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[ADDR_WIDTH-1:0];
              mem_wdata <= {byte_data, word_buf};
              word_idx  <= word_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed frames driven serially into two loader instances (ADDR_WIDTH 10 and 2).
`default_nettype none

module tb_uart_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_a = 1'b1;
  logic        rx_b = 1'b1;

  logic        a_we, a_hold, a_done, a_err;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_we, b_hold, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] a_addr_q[$];
  logic [31:0] a_data_q[$];
  int          b_cnt = 0;
  logic [31:0] b_last_addr = '0;
  logic [31:0] b_last_data = '0;

  always #5 clk = ~clk;

  uart_loader #(.CLK_FREQ(100), .BAUD(10), .ADDR_WIDTH(10)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .cpu_hold(a_hold), .done(a_done), .error(a_err)
  );

  uart_loader #(.CLK_FREQ(100), .BAUD(10), .ADDR_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .cpu_hold(b_hold), .done(b_done), .error(b_err)
  );

  always @(posedge clk) begin
    if (a_we) begin
      a_addr_q.push_back(32'(a_addr));
      a_data_q.push_back(a_wdata);
    end
    if (b_we) begin
      b_cnt = b_cnt + 1;
      b_last_addr = 32'(b_addr);
      b_last_data = b_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr_addr(input int i);
    return (i < a_addr_q.size()) ? a_addr_q[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wr_data(input int i);
    return (i < a_data_q.size()) ? a_data_q[i] : 32'hxxxxxxxx;
  endfunction

  task automatic drive(input bit to_b, input logic v);
    if (to_b) rx_b = v;
    else      rx_a = v;
  endtask

  task automatic send_byte(input bit to_b, input logic [7:0] b, input bit good_stop);
    drive(to_b, 1'b0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(to_b, b[i]);
      repeat (10) @(negedge clk);
    end
    drive(to_b, good_stop);
    repeat (10) @(negedge clk);
    drive(to_b, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    a_addr_q.delete();
    a_data_q.delete();
    b_cnt = 0;
    b_last_addr = '0;
    b_last_data = '0;
  endtask

  task automatic send_frame1();
    send_byte(0, 8'h02, 1); send_byte(0, 8'h00, 1);
    send_byte(0, 8'h78, 1); send_byte(0, 8'h56, 1); send_byte(0, 8'h34, 1); send_byte(0, 8'h12, 1);
    send_byte(0, 8'hEF, 1); send_byte(0, 8'hBE, 1); send_byte(0, 8'hAD, 1); send_byte(0, 8'hDE, 1);
`ifdef LOADER_CHECKSUM_EN
    // XOR of the eight data bytes: 08 ^ 22 = 2A.
    send_byte(0, 8'h2A, 1);
`endif
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_we",    32'(a_we), 32'd0);
    check("rst_addr",  32'(a_addr), 32'd0);
    check("rst_wdata", a_wdata, 32'd0);
    check("rst_hold",  32'(a_hold), 32'd1);
    check("rst_done",  32'(a_done), 32'd0);
    check("rst_err",   32'(a_err), 32'd0);
    check("rst_b_hold", 32'(b_hold), 32'd1);

    // Two-word image
    send_frame1();
    check("f1_nwr",   32'(a_addr_q.size()), 32'd2);
    check("f1_a0",    wr_addr(0), 32'd0);
    check("f1_d0",    wr_data(0), 32'h12345678);
    check("f1_a1",    wr_addr(1), 32'd1);
    check("f1_d1",    wr_data(1), 32'hDEADBEEF);
    check("f1_hold",  32'(a_hold), 32'd0);
    check("f1_done",  32'(a_done), 32'd1);
    check("f1_err",   32'(a_err), 32'd0);
    // Traffic after done, even a framing fault, is ignored
    send_byte(0, 8'h55, 0);
    send_byte(0, 8'h00, 1);
    check("post_done_done", 32'(a_done), 32'd1);
    check("post_done_err",  32'(a_err), 32'd0);
    check("post_done_nwr",  32'(a_addr_q.size()), 32'd2);

    // One word, wrong checksum
    do_reset();
    send_byte(0, 8'h01, 1); send_byte(0, 8'h00, 1);
    send_byte(0, 8'h01, 1); send_byte(0, 8'h02, 1); send_byte(0, 8'h03, 1); send_byte(0, 8'h04, 1);
    check("f2_nwr", 32'(a_addr_q.size()), 32'd1);
    check("f2_a0",  wr_addr(0), 32'd0);
    check("f2_d0",  wr_data(0), 32'h04030201);
`ifdef LOADER_CHECKSUM_EN
    send_byte(0, 8'h05, 1);
    check("f2_err",  32'(a_err), 32'd1);
    check("f2_hold", 32'(a_hold), 32'd1);
    check("f2_done", 32'(a_done), 32'd0);
`else
    check("f2_done", 32'(a_done), 32'd1);
    check("f2_hold", 32'(a_hold), 32'd0);
`endif

    // Framing fault on the first byte
    do_reset();
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h00, 1);
    check("fe_err",  32'(a_err), 32'd1);
    check("fe_hold", 32'(a_hold), 32'd1);
    check("fe_nwr",  32'(a_addr_q.size()), 32'd0);

    // Length boundaries: 1025 > 2**10 rejected; on the 2-bit instance 5 rejected, 4 accepted
    do_reset();
    send_byte(0, 8'h01, 1); send_byte(0, 8'h04, 1);
    send_byte(0, 8'h00, 1);
    check("n1025_err", 32'(a_err), 32'd1);
    check("n1025_nwr", 32'(a_addr_q.size()), 32'd0);
    send_byte(1, 8'h05, 1); send_byte(1, 8'h00, 1);
    check("n5_err", 32'(b_err), 32'd1);
    check("n5_nwr", 32'(b_cnt), 32'd0);
    do_reset();
    send_byte(1, 8'h04, 1); send_byte(1, 8'h00, 1);
    for (int k = 0; k < 4; k++) begin
      send_byte(1, 8'(k), 1); send_byte(1, 8'h00, 1); send_byte(1, 8'h00, 1); send_byte(1, 8'h00, 1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(1, 8'h00, 1);
`endif
    check("n4_nwr",   32'(b_cnt), 32'd4);
    check("n4_laddr", b_last_addr, 32'd3);
    check("n4_ldata", b_last_data, 32'd3);
    check("n4_done",  32'(b_done), 32'd1);
    check("n4_err",   32'(b_err), 32'd0);

    // 4-cycle glitch is not a start bit, then an empty image
    do_reset();
    @(negedge clk);
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (150) @(negedge clk);
    check("gl_done", 32'(a_done), 32'd0);
    check("gl_err",  32'(a_err), 32'd0);
    send_byte(0, 8'h00, 1); send_byte(0, 8'h00, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(0, 8'h00, 1);
`endif
    check("n0_done", 32'(a_done), 32'd1);
    check("n0_hold", 32'(a_hold), 32'd0);
    check("n0_nwr",  32'(a_addr_q.size()), 32'd0);

    // Reset after three data bytes discards the partial word and length
    do_reset();
    send_byte(0, 8'h01, 1); send_byte(0, 8'h00, 1);
    send_byte(0, 8'hAA, 1); send_byte(0, 8'hBB, 1); send_byte(0, 8'hCC, 1);
    do_reset();
    check("mr_done", 32'(a_done), 32'd0);
    send_frame1();
    check("mr_nwr",  32'(a_addr_q.size()), 32'd2);
    check("mr_a0",   wr_addr(0), 32'd0);
    check("mr_d0",   wr_data(0), 32'h12345678);
    check("mr_a1",   wr_addr(1), 32'd1);
    check("mr_d1",   wr_data(1), 32'hDEADBEEF);
    check("mr_done2", 32'(a_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
